gemm_seq_ctrl: RTL and testbench

Host-side sequencer for the GEMM core and its three dual-port BRAMs. It loads data into the ifmap BRAM (mem0) and the weight BRAM (mem1) through port 1 from one valid/ready input stream. It then resets and starts GEMM, waits for finish, and drains the ofmap BRAM (mem2) port 1 to a valid/ready output stream. The block replaces the manual file-load and dump sequence used around GEMM, so the core can run from an on-chip host interface.

---
 rtl/gemm_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_gemm_seq_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: loads the ifmap/weight BRAMs from one input stream, resets and runs GEMM, then drains the ofmap BRAM to an output stream.
// Latency: a BRAM write lands 1 cycle after its word is accepted; a drained word reaches the output FIFO 1 cycle after its read is issued.
// Backpressure: s_ready_o is high only while loading; mem2 reads stall whenever the 2-entry output FIFO plus the in-flight read would overflow.
// Optional: define GEMM_TIMEOUT_EN to build a GRUN watchdog that sets err_o and skips DRAIN.
module gemm_seq_ctrl #(
   parameter int DWIDTH          = 112,
   parameter int MEM0_DEPTH      = 4116,
   parameter int MEM0_ADDR_WIDTH = 13,
   parameter int MEM1_DEPTH      = 1470,
   parameter int MEM1_ADDR_WIDTH = 11,
   parameter int MEM2_DEPTH      = 896,
   parameter int MEM2_ADDR_WIDTH = 10,
   parameter int TIMEOUT_CYCLES  = 1048576
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_start_i,
   input  logic                       s_valid_i,
   input  logic [DWIDTH-1:0]          s_data_i,
   output logic                       s_ready_o,
   output logic                       mem0_ce1_o,
   output logic                       mem0_we1_o,
   output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr1_o,
   output logic [DWIDTH-1:0]          mem0_d1_o,
   output logic                       mem1_ce1_o,
   output logic                       mem1_we1_o,
   output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr1_o,
   output logic [DWIDTH-1:0]          mem1_d1_o,
   output logic                       gemm_rst_n_o,
   output logic                       gemm_start_o,
   input  logic                       gemm_finish_i,
   output logic                       mem2_ce1_o,
   output logic                       mem2_we1_o,
   output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1_o,
   input  logic [DWIDTH-1:0]          mem2_q1_i,
   output logic                       m_valid_o,
   output logic [DWIDTH-1:0]          m_data_o,
   input  logic                       m_ready_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   // One load counter serves both memories, so it is as wide as the wider address.
   localparam int CW = (MEM0_ADDR_WIDTH > MEM1_ADDR_WIDTH) ? MEM0_ADDR_WIDTH : MEM1_ADDR_WIDTH;
   localparam int AW2 = MEM2_ADDR_WIDTH;
   localparam logic [CW-1:0]  CNT0_LAST = CW'(MEM0_DEPTH - 1);
   localparam logic [CW-1:0]  CNT1_LAST = CW'(MEM1_DEPTH - 1);
   localparam logic [AW2-1:0] RD_LAST   = AW2'(MEM2_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_I, S_LOAD_W, S_GRST, S_GRUN, S_DRAIN, S_DONE
   } state_t;

   state_t state_q, state_d;

   // Load side: counter, registered write strobe/address/data, last-weight flag
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              w_last_q, w_last_d;
   logic              mem0_wr_q, mem0_wr_d;
   logic              mem1_wr_q, mem1_wr_d;
   logic [CW-1:0]     waddr_q, waddr_d;
   logic [DWIDTH-1:0] wdat_q, wdat_d;

   // Second GEMM reset pulse, issued on the cycle after GRUN ends
   logic              grst2_q, grst2_d;

   // Drain side: read address, read-in-flight, pop count, 2-entry FIFO
   logic [AW2-1:0]    rd_addr_q, rd_addr_d;
   logic              rd_done_q, rd_done_d;
   logic              rd_vld_q, rd_vld_d;
   logic [AW2-1:0]    pop_cnt_q, pop_cnt_d;
   logic [DWIDTH-1:0] fifo0_q, fifo0_d;
   logic [DWIDTH-1:0] fifo1_q, fifo1_d;
   logic              wp_q, wp_d;
   logic              rp_q, rp_d;
   logic [1:0]        occ_q, occ_d;

   // Decoded handshakes
   logic       load_rdy, s_acc, last_i, last_w;
   logic       fifo_vld, pop, push, rd_issue, last_pop, wd_hit;
   logic [1:0] occ_eff;

`ifdef GEMM_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   logic [WDW-1:0] wd_q, wd_d;
   logic           err_q, err_d;
`endif

   // Handshake, credit and terminal-count decode
   always_comb begin
      load_rdy = (state_q == S_LOAD_I) || ((state_q == S_LOAD_W) && !w_last_q);
      s_acc    = s_valid_i && load_rdy;
      last_i   = (state_q == S_LOAD_I) && s_acc && (cnt_q == CNT0_LAST);
      last_w   = (state_q == S_LOAD_W) && s_acc && (cnt_q == CNT1_LAST);
      fifo_vld = (occ_q != 2'd0);
      pop      = fifo_vld && m_ready_i;
      push     = rd_vld_q;
      // Credit counts the slot freed by this cycle's pop, so a steady
      // ready stream sustains one read per cycle.
      occ_eff  = occ_q - {1'b0, pop};
      rd_issue = (state_q == S_DRAIN) && !rd_done_q && ((occ_eff + {1'b0, rd_vld_q}) < 2'd2);
      last_pop = (state_q == S_DRAIN) && pop && (pop_cnt_q == RD_LAST);
`ifdef GEMM_TIMEOUT_EN
      wd_hit   = (state_q == S_GRUN) && (wd_q == WD_LAST);
`else
      wd_hit   = 1'b0;
`endif
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; finish wins over a same-cycle timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cmd_start_i) state_d = S_LOAD_I;
         S_LOAD_I: if (last_i) state_d = S_LOAD_W;
         S_LOAD_W: if (w_last_q) state_d = S_GRST;
         S_GRST:   state_d = S_GRUN;
         S_GRUN: begin
            if (gemm_finish_i) state_d = S_DRAIN;
            else if (wd_hit)   state_d = S_DONE;
         end
         S_DRAIN:  if (last_pop) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: load counter, write registers, drain counters, FIFO
   always_comb begin
      cnt_d     = cnt_q;
      w_last_d  = w_last_q;
      mem0_wr_d = 1'b0;
      mem1_wr_d = 1'b0;
      waddr_d   = waddr_q;
      wdat_d    = wdat_q;
      grst2_d   = (state_q == S_GRUN) && (gemm_finish_i || wd_hit);
      rd_addr_d = rd_addr_q;
      rd_done_d = rd_done_q;
      rd_vld_d  = rd_issue;
      pop_cnt_d = pop_cnt_q;
      fifo0_d   = fifo0_q;
      fifo1_d   = fifo1_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      occ_d     = occ_q + {1'b0, push} - {1'b0, pop};

      if (s_acc) begin
         waddr_d   = cnt_q;
         wdat_d    = s_data_i;
         mem0_wr_d = (state_q == S_LOAD_I);
         mem1_wr_d = (state_q == S_LOAD_W);
         cnt_d     = (last_i || last_w) ? '0 : cnt_q + CW'(1);
      end

      // Holds s_ready_o low for the cycle that issues the final weight write
      if (last_w)                    w_last_d = 1'b1;
      else if (state_q != S_LOAD_W)  w_last_d = 1'b0;

      if (rd_issue) begin
         if (rd_addr_q == RD_LAST) rd_done_d = 1'b1;
         else                      rd_addr_d = rd_addr_q + AW2'(1);
      end

      if (pop) begin
         rp_d = !rp_q;
         if (pop_cnt_q != RD_LAST) pop_cnt_d = pop_cnt_q + AW2'(1);
      end

      if (push) begin
         if (wp_q) fifo1_d = mem2_q1_i;
         else      fifo0_d = mem2_q1_i;
         wp_d = !wp_q;
      end

      // Rewind the drain counters so the next job starts at address 0
      if (state_q == S_DONE) begin
         rd_addr_d = '0;
         rd_done_d = 1'b0;
         pop_cnt_d = '0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         w_last_q  <= 1'b0;
         mem0_wr_q <= 1'b0;
         mem1_wr_q <= 1'b0;
         waddr_q   <= '0;
         wdat_q    <= '0;
         grst2_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_done_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         pop_cnt_q <= '0;
         fifo0_q   <= '0;
         fifo1_q   <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         occ_q     <= 2'd0;
      end else begin
         cnt_q     <= cnt_d;
         w_last_q  <= w_last_d;
         mem0_wr_q <= mem0_wr_d;
         mem1_wr_q <= mem1_wr_d;
         waddr_q   <= waddr_d;
         wdat_q    <= wdat_d;
         grst2_q   <= grst2_d;
         rd_addr_q <= rd_addr_d;
         rd_done_q <= rd_done_d;
         rd_vld_q  <= rd_vld_d;
         pop_cnt_q <= pop_cnt_d;
         fifo0_q   <= fifo0_d;
         fifo1_q   <= fifo1_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         occ_q     <= occ_d;
      end
   end

`ifdef GEMM_TIMEOUT_EN
   // Watchdog counts GRUN cycles; the error flag is sticky until the next start
   always_comb begin
      wd_d  = (state_q == S_GRUN) ? wd_q + WDW'(1) : '0;
      err_d = err_q;
      if ((state_q == S_IDLE) && cmd_start_i)                  err_d = 1'b0;
      else if ((state_q == S_GRUN) && wd_hit && !gemm_finish_i) err_d = 1'b1;
   end

   // Watchdog registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
`endif

   // Output decode
   always_comb begin
      s_ready_o    = load_rdy;
      mem0_ce1_o   = mem0_wr_q;
      mem0_we1_o   = mem0_wr_q;
      mem0_addr1_o = waddr_q[MEM0_ADDR_WIDTH-1:0];
      mem0_d1_o    = wdat_q;
      mem1_ce1_o   = mem1_wr_q;
      mem1_we1_o   = mem1_wr_q;
      mem1_addr1_o = waddr_q[MEM1_ADDR_WIDTH-1:0];
      mem1_d1_o    = wdat_q;
      gemm_rst_n_o = !((state_q == S_GRST) || grst2_q);
      gemm_start_o = (state_q == S_GRUN);
      mem2_ce1_o   = rd_issue;
      mem2_we1_o   = 1'b0;
      mem2_addr1_o = rd_addr_q;
      m_valid_o    = fifo_vld;
      m_data_o     = rp_q ? fifo1_q : fifo0_q;
      busy_o       = (state_q != S_IDLE);
      done_o       = (state_q == S_DONE);
`ifdef GEMM_TIMEOUT_EN
      err_o        = err_q;
`else
      err_o        = 1'b0;
`endif
   end

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Bench for gemm_seq_ctrl with small BRAM depths (8/4/6) and a GEMM model that finishes 20 cycles after start.
// Write strobes and output words are checked against scoreboard queues filled when stimulus is driven.
// Build with GEMM_TIMEOUT_EN defined to also exercise the 16-cycle watchdog.
`timescale 1ns/1ps
module tb_gemm_seq_ctrl;
   localparam int DW = 112;
   localparam int D0 = 8;
   localparam int D1 = 4;
   localparam int D2 = 6;
   localparam int A0 = 13;
   localparam int A1 = 11;
   localparam int A2 = 10;
`ifdef GEMM_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1048576;
`endif

   logic          clk, rst, cmd_start_i, s_valid_i, s_ready_o;
   logic [DW-1:0] s_data_i;
   logic          mem0_ce1_o, mem0_we1_o, mem1_ce1_o, mem1_we1_o;
   logic [A0-1:0] mem0_addr1_o;
   logic [A1-1:0] mem1_addr1_o;
   logic [DW-1:0] mem0_d1_o, mem1_d1_o;
   logic          gemm_rst_n_o, gemm_start_o, gemm_finish_i;
   logic          mem2_ce1_o, mem2_we1_o;
   logic [A2-1:0] mem2_addr1_o;
   logic [DW-1:0] mem2_q1_i, m_data_o;
   logic          m_valid_o, m_ready_i, busy_o, done_o, err_o;

   gemm_seq_ctrl #(
      .DWIDTH(DW), .MEM0_DEPTH(D0), .MEM0_ADDR_WIDTH(A0),
      .MEM1_DEPTH(D1), .MEM1_ADDR_WIDTH(A1),
      .MEM2_DEPTH(D2), .MEM2_ADDR_WIDTH(A2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .cmd_start_i(cmd_start_i),
      .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
      .mem0_ce1_o(mem0_ce1_o), .mem0_we1_o(mem0_we1_o), .mem0_addr1_o(mem0_addr1_o), .mem0_d1_o(mem0_d1_o),
      .mem1_ce1_o(mem1_ce1_o), .mem1_we1_o(mem1_we1_o), .mem1_addr1_o(mem1_addr1_o), .mem1_d1_o(mem1_d1_o),
      .gemm_rst_n_o(gemm_rst_n_o), .gemm_start_o(gemm_start_o), .gemm_finish_i(gemm_finish_i),
      .mem2_ce1_o(mem2_ce1_o), .mem2_we1_o(mem2_we1_o), .mem2_addr1_o(mem2_addr1_o), .mem2_q1_i(mem2_q1_i),
      .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit            mem;
      int            addr;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_w[$];
   logic [DW-1:0] exp_out[$];
   logic [DW-1:0] tb_mem0 [0:(1<<A0)-1];
   logic [DW-1:0] tb_mem1 [0:(1<<A1)-1];
   logic [DW-1:0] tb_mem2 [0:(1<<A2)-1];

   int errors = 0;
   int checks = 0;
   int reads, pops, rd_idx, done_cnt, grst_lo, grst_at_start, start_cyc, busy_drop, max_out;
   int mcyc = 0, first_pop, last_pop, run_cnt = 0;
   bit start_seen, job_active, fin_en;

   function automatic logic [DW-1:0] word_of(input int job, input int k);
      return {16'(job), 80'd0, 16'(k)};
   endfunction

   // BRAM models: mem0/mem1 capture port-1 writes; mem2 returns data one cycle after ce
   always @(posedge clk) begin
      if (mem0_ce1_o && mem0_we1_o) tb_mem0[mem0_addr1_o] <= mem0_d1_o;
      if (mem1_ce1_o && mem1_we1_o) tb_mem1[mem1_addr1_o] <= mem1_d1_o;
      if (mem2_ce1_o) mem2_q1_i <= tb_mem2[mem2_addr1_o];
   end

   // GEMM model: finish rises after start has been high for 20 cycles
   always @(negedge clk) begin
      if (gemm_start_o) run_cnt++;
      else              run_cnt = 0;
      gemm_finish_i = fin_en && gemm_start_o && (run_cnt >= 20);
   end

   // Monitor: pops the scoreboards on every write strobe and output handshake
   always @(negedge clk) begin
      wr_t e;
      mcyc++;
      if (mem0_ce1_o) begin
         checks++;
         if (exp_w.size() == 0) begin
            errors++;
            $display("FAIL wr0_extra: strobe at addr=%0d, no write expected", mem0_addr1_o);
         end else begin
            e = exp_w.pop_front();
            if (mem0_we1_o !== 1'b1 || e.mem !== 1'b0 || int'(mem0_addr1_o) !== e.addr || mem0_d1_o !== e.d) begin
               errors++;
               $display("FAIL wr0: got we=%0b addr=%0d d=%h, want mem%0d addr=%0d d=%h",
                        mem0_we1_o, mem0_addr1_o, mem0_d1_o, e.mem, e.addr, e.d);
            end
         end
      end
      if (mem1_ce1_o) begin
         checks++;
         if (exp_w.size() == 0) begin
            errors++;
            $display("FAIL wr1_extra: strobe at addr=%0d, no write expected", mem1_addr1_o);
         end else begin
            e = exp_w.pop_front();
            if (mem1_we1_o !== 1'b1 || e.mem !== 1'b1 || int'(mem1_addr1_o) !== e.addr || mem1_d1_o !== e.d) begin
               errors++;
               $display("FAIL wr1: got we=%0b addr=%0d d=%h, want mem%0d addr=%0d d=%h",
                        mem1_we1_o, mem1_addr1_o, mem1_d1_o, e.mem, e.addr, e.d);
            end
         end
      end
      if (mem2_ce1_o) begin
         checks++;
         if (mem2_we1_o !== 1'b0 || int'(mem2_addr1_o) !== rd_idx) begin
            errors++;
            $display("FAIL rd2: got we=%0b addr=%0d, want we=0 addr=%0d", mem2_we1_o, mem2_addr1_o, rd_idx);
         end
         rd_idx++;
         reads++;
      end
      if (m_valid_o && m_ready_i) begin
         checks++;
         if (exp_out.size() == 0) begin
            errors++;
            $display("FAIL out_extra: got %h, no word expected", m_data_o);
         end else if (m_data_o !== exp_out[0]) begin
            errors++;
            $display("FAIL out_data: got %h, want %h", m_data_o, exp_out[0]);
            void'(exp_out.pop_front());
         end else begin
            void'(exp_out.pop_front());
         end
         if (first_pop < 0) first_pop = mcyc;
         last_pop = mcyc;
         pops++;
      end
      if (reads - pops > max_out) max_out = reads - pops;
      if (!gemm_rst_n_o) grst_lo++;
      if (gemm_start_o) begin
         start_cyc++;
         if (!start_seen) begin
            start_seen    = 1'b1;
            grst_at_start = grst_lo;
         end
      end
      if (job_active && !busy_o) busy_drop++;
      if (done_o) begin
         done_cnt++;
         job_active = 1'b0;
      end
   end

   task automatic clear_mon();
      reads = 0; pops = 0; rd_idx = 0; done_cnt = 0; grst_lo = 0; grst_at_start = -1;
      start_cyc = 0; busy_drop = 0; max_out = 0; first_pop = -1; last_pop = -1; start_seen = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 cmd_start_i = 1'b1;
      @(posedge clk); #1 cmd_start_i = 1'b0;
      job_active = 1'b1;
   endtask

   // Streams words first..first+n-1; gap=1 uses the valid pattern 1,0,0,1
   task automatic stream_words(input int job, input int first, input int n, input int gap, output bit to);
      int k = 0;
      int cyc = 0;
      wr_t e;
      while (k < n && cyc < 400) begin
         @(posedge clk); #1;
         s_valid_i = (gap == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         s_data_i  = word_of(job, first + k);
         @(negedge clk);
         if (s_valid_i && s_ready_o) begin
            e.mem  = (first + k >= D0);
            e.addr = (first + k >= D0) ? first + k - D0 : first + k;
            e.d    = s_data_i;
            exp_w.push_back(e);
            k++;
         end
         cyc++;
      end
      @(posedge clk); #1 s_valid_i = 1'b0;
      to = (k < n);
   endtask

   task automatic wait_done(input int rdy_pct, input bit poke, output bit to);
      int cyc = 0;
      bit poked = 0;
      while (done_cnt == 0 && cyc < 1000) begin
         @(posedge clk); #1;
         m_ready_i = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
         if (poke && !poked && gemm_start_o) begin
            cmd_start_i = 1'b1;
            poked = 1'b1;
         end else begin
            cmd_start_i = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      @(posedge clk); #1;
      cmd_start_i = 1'b0;
      m_ready_i   = 1'b1;
      to = (done_cnt == 0);
   endtask

   task automatic drive_job(input int job, input int gap, input int rdy_pct, input bit poke,
                            input bit drain, output bit to);
      bit t1, t2;
      clear_mon();
      for (int i = 0; i < D2; i++) begin
         tb_mem2[i] = DW'({$urandom, $urandom, $urandom, $urandom});
         if (drain) exp_out.push_back(tb_mem2[i]);
      end
      pulse_start();
      stream_words(job, 0, D0 + D1, gap, t1);
      wait_done(rdy_pct, poke, t2);
      repeat (10) @(posedge clk);
      #1;
      to = t1 | t2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready_o, mem0_ce1_o, mem0_we1_o, mem1_ce1_o, mem1_we1_o, gemm_rst_n_o, gemm_start_o,
           mem2_ce1_o, mem2_we1_o, m_valid_o, busy_o, done_o, err_o} !== 13'b0000010000000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, want 0000010000000",
                  {s_ready_o, mem0_ce1_o, mem0_we1_o, mem1_ce1_o, mem1_we1_o, gemm_rst_n_o, gemm_start_o,
                   mem2_ce1_o, mem2_we1_o, m_valid_o, busy_o, done_o, err_o});
      end
      checks++;
      if ({mem0_addr1_o, mem1_addr1_o, mem2_addr1_o} !== '0 || mem0_d1_o !== '0 || mem1_d1_o !== '0 || m_data_o !== '0) begin
         errors++;
         $display("FAIL reset_bus: addr0=%0d addr1=%0d addr2=%0d d0=%h d1=%h m=%h, want all 0",
                  mem0_addr1_o, mem1_addr1_o, mem2_addr1_o, mem0_d1_o, mem1_d1_o, m_data_o);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_nominal();
      bit to;
      drive_job(1, 0, 100, 0, 1, to);
      checks++;
      if (to || done_cnt !== 1) begin
         errors++;
         $display("FAIL nom_done: timeout=%0b done pulses=%0d, want 0/1", to, done_cnt);
      end
      checks++;
      if (pops !== D2 || reads !== D2 || exp_out.size() !== 0 || exp_w.size() !== 0) begin
         errors++;
         $display("FAIL nom_counts: pops=%0d reads=%0d left_out=%0d left_wr=%0d, want 6/6/0/0",
                  pops, reads, exp_out.size(), exp_w.size());
      end
      checks++;
      if (grst_at_start !== 1 || grst_lo !== 2) begin
         errors++;
         $display("FAIL nom_grst: low before start=%0d total=%0d, want 1/2", grst_at_start, grst_lo);
      end
      checks++;
      if (last_pop - first_pop !== D2 - 1) begin
         errors++;
         $display("FAIL nom_thruput: pop span=%0d cycles, want %0d", last_pop - first_pop, D2 - 1);
      end
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL nom_idle: err=%0b busy=%0b, want 0/0", err_o, busy_o);
      end
      for (int i = 0; i < D0 + D1; i++) begin
         logic [DW-1:0] got;
         got = (i < D0) ? tb_mem0[i] : tb_mem1[i - D0];
         checks++;
         if (got !== word_of(1, i)) begin
            errors++;
            $display("FAIL nom_mem word %0d: got %h, want %h", i, got, word_of(1, i));
         end
      end
   endtask

   task automatic test_input_gaps();
      bit to;
      drive_job(2, 1, 100, 0, 1, to);
      checks++;
      if (to || done_cnt !== 1 || exp_w.size() !== 0 || exp_out.size() !== 0) begin
         errors++;
         $display("FAIL gap_job: timeout=%0b done=%0d left_wr=%0d left_out=%0d, want 0/1/0/0",
                  to, done_cnt, exp_w.size(), exp_out.size());
      end
      checks++;
      if (busy_drop !== 0) begin
         errors++;
         $display("FAIL gap_busy: busy low for %0d cycles mid-job, want 0", busy_drop);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      drive_job(3, 0, 50, 0, 1, to);
      checks++;
      if (to || done_cnt !== 1 || pops !== D2 || exp_out.size() !== 0) begin
         errors++;
         $display("FAIL bp_job: timeout=%0b done=%0d pops=%0d left_out=%0d, want 0/1/6/0",
                  to, done_cnt, pops, exp_out.size());
      end
      checks++;
      if (max_out > 2 || reads !== D2) begin
         errors++;
         $display("FAIL bp_credit: max outstanding=%0d reads=%0d, want <=2 and 6", max_out, reads);
      end
   endtask

   task automatic test_start_busy();
      bit to;
      drive_job(4, 0, 100, 1, 1, to);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (to || done_cnt !== 1 || busy_o !== 1'b0 || pops !== D2) begin
         errors++;
         $display("FAIL busy_start: timeout=%0b done=%0d busy=%0b pops=%0d, want 0/1/0/6",
                  to, done_cnt, busy_o, pops);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      clear_mon();
      pulse_start();
      stream_words(5, 0, D0 + 2, 0, to);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (to || {s_ready_o, mem0_ce1_o, mem1_ce1_o, gemm_rst_n_o, gemm_start_o, mem2_ce1_o, m_valid_o,
                 busy_o, done_o, err_o} !== 10'b0001000000) begin
         errors++;
         $display("FAIL midrst_ctrl: timeout=%0b got %b, want 0001000000", to,
                  {s_ready_o, mem0_ce1_o, mem1_ce1_o, gemm_rst_n_o, gemm_start_o, mem2_ce1_o, m_valid_o,
                   busy_o, done_o, err_o});
      end
      checks++;
      if (mem1_addr1_o !== '0 || mem1_d1_o !== '0 || exp_w.size() !== 1) begin
         errors++;
         $display("FAIL midrst_wr: addr1=%0d d1=%h pending=%0d, want 0/0/1", mem1_addr1_o, mem1_d1_o, exp_w.size());
      end
      exp_w.delete();
      @(posedge clk); #1 rst = 1'b0;
      drive_job(6, 0, 100, 0, 1, to);
      checks++;
      if (to || done_cnt !== 1 || pops !== D2 || exp_w.size() !== 0 || tb_mem1[3] !== word_of(6, D0 + 3)) begin
         errors++;
         $display("FAIL midrst_rerun: timeout=%0b done=%0d pops=%0d left_wr=%0d mem1[3]=%h",
                  to, done_cnt, pops, exp_w.size(), tb_mem1[3]);
      end
   endtask

`ifdef GEMM_TIMEOUT_EN
   task automatic test_timeout();
      bit to;
      fin_en = 1'b0;
      drive_job(7, 0, 100, 0, 0, to);
      checks++;
      if (to || done_cnt !== 1 || reads !== 0) begin
         errors++;
         $display("FAIL to_job: timeout=%0b done=%0d reads=%0d, want 0/1/0", to, done_cnt, reads);
      end
      checks++;
      if (start_cyc !== TO || err_o !== 1'b1 || grst_lo !== 2) begin
         errors++;
         $display("FAIL to_err: start cycles=%0d err=%0b grst lows=%0d, want %0d/1/2", start_cyc, err_o, grst_lo, TO);
      end
      pulse_start();
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL to_clear: err=%0b busy=%0b after new start, want 0/1", err_o, busy_o);
      end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      fin_en = 1'b1;
   endtask
`endif

   initial begin
      rst         = 1'b1;
      cmd_start_i = 1'b0;
      s_valid_i   = 1'b0;
      s_data_i    = '0;
      m_ready_i   = 1'b1;
      fin_en      = 1'b1;
      job_active  = 1'b0;
      clear_mon();
      test_reset();
      test_nominal();
      test_input_gaps();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
`ifdef GEMM_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
